// File: rtl/serial_add_sequencer.sv
// Feeds operand pairs from a 2-entry FIFO to an external serial adder and
// returns each sum through a valid/ready result register.
module serial_add_sequencer #(
    parameter int unsigned LATENCY = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic       add_resetn,
    output logic       add_start,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    input  logic [8:0] add_sum,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] out_sum,
    output logic [7:0] result_count,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(LATENCY);
    localparam int unsigned PAIR_W = 16;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              pop;
    logic              capture;
    logic              push;
    logic [CNT_W-1:0]  wait_cnt;
    logic [PAIR_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_cnt;
    logic [7:0]        op_a;
    logic [7:0]        op_b;

    assign in_ready   = (fifo_cnt != 2'd2);
    assign push       = in_valid & in_ready;
    assign add_resetn = ~reset;
    assign add_a      = op_a;
    assign add_b      = op_b;
    assign busy       = (state != IDLE) || (fifo_cnt != 2'd0);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle strobes
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_cnt != 2'd0) begin
                    pop        = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: state_next = WAIT;
            WAIT: begin
                if (wait_cnt == CNT_W'(LATENCY - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!out_valid || out_ready) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand FIFO; a push while full is blocked by in_ready
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {in_a, in_b};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Adder handshake: operands load on pop, start pulses only in LAUNCH
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_a      <= 8'd0;
            op_b      <= 8'd0;
            add_start <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            if (pop) begin
                {op_a, op_b} <= fifo_mem[rd_ptr];
            end
            add_start <= (state_next == LAUNCH);
            if (state == LAUNCH) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    // Result register; a capture wins over a same-cycle consume
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_sum      <= 9'd0;
            result_count <= 8'd0;
        end else begin
            if (capture) begin
                out_valid    <= 1'b1;
                out_sum      <= add_sum;
                result_count <= result_count + 8'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer with a bit-serial adder model
// and a scoreboard of expected sums.
module tb_serial_add_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic       add_resetn;
    logic       add_start;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic [8:0] add_sum;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [8:0] out_sum;
    logic [7:0] result_count;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [8:0] sb [$];
    logic [8:0] mon_exp;

    serial_add_sequencer #(.LATENCY(10)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .add_resetn(add_resetn), .add_start(add_start),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .result_count(result_count), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Bit-serial adder: latches operands on add_start, one bit per cycle, then holds
    logic [7:0] ra, rb;
    logic [8:0] acc;
    logic       carry, run;
    logic [3:0] idx;
    always @(posedge clock or negedge add_resetn) begin
        if (!add_resetn) begin
            ra <= 8'd0; rb <= 8'd0; acc <= 9'd0; carry <= 1'b0; run <= 1'b0; idx <= 4'd0;
        end else if (add_start) begin
            ra <= add_a; rb <= add_b; acc <= 9'd0; carry <= 1'b0; run <= 1'b1; idx <= 4'd0;
        end else if (run) begin
            acc[idx] <= ra[idx[2:0]] ^ rb[idx[2:0]] ^ carry;
            carry    <= (ra[idx[2:0]] & rb[idx[2:0]]) | (carry & (ra[idx[2:0]] ^ rb[idx[2:0]]));
            if (idx == 4'd7) begin
                run    <= 1'b0;
                acc[8] <= (ra[7] & rb[7]) | (carry & (ra[7] ^ rb[7]));
            end
            idx <= idx + 4'd1;
        end
    end
    assign add_sum = acc;

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        @(negedge clock);
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout in_ready=%b exp=1", in_ready);
        end else begin
            in_valid = 1'b1; in_a = a; in_b = b;
            sb.push_back(9'(a) + 9'(b));
            @(posedge clock);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy || out_valid) && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d busy=%b exp=0/0", sb.size(), busy);
        end
    endtask

    task automatic test_reset();
        #2;
        checks += 9;
        if (in_ready !== 1'b1)      begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        if (add_resetn !== 1'b0)    begin errors++; $display("FAIL rst_add_resetn got=%b exp=0", add_resetn); end
        if (add_start !== 1'b0)     begin errors++; $display("FAIL rst_add_start got=%b exp=0", add_start); end
        if (add_a !== 8'h00)        begin errors++; $display("FAIL rst_add_a got=%h exp=00", add_a); end
        if (add_b !== 8'h00)        begin errors++; $display("FAIL rst_add_b got=%h exp=00", add_b); end
        if (out_valid !== 1'b0)     begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        if (out_sum !== 9'h000)     begin errors++; $display("FAIL rst_out_sum got=%h exp=000", out_sum); end
        if (result_count !== 8'h00) begin errors++; $display("FAIL rst_count got=%h exp=00", result_count); end
        if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset_midop();
        int n = 0;
        bit seen = 0;
        out_ready = 1'b1;
        push_pair(8'h55, 8'h22);
        push_pair(8'h01, 8'h02);
        push_pair(8'h03, 8'h04);
        while (!add_start && n < 20) begin
            @(negedge clock);
            n++;
        end
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        sb.delete();
        checks += 4;
        if (add_start !== 1'b0)  begin errors++; $display("FAIL midrst_add_start got=%b exp=0", add_start); end
        if (add_resetn !== 1'b0) begin errors++; $display("FAIL midrst_add_resetn got=%b exp=0", add_resetn); end
        if (out_valid !== 1'b0)  begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        repeat (40) begin
            @(negedge clock);
            if (out_valid) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midrst_no_output got=1 exp=0"); end
    endtask

    task automatic test_single();
        int n = 0;
        out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h01;
        sb.push_back(9'h100);
        @(posedge clock);
        #1 in_valid = 1'b0;
        while (!out_valid && n < 40) begin
            @(posedge clock);
            #1 n++;
        end
        checks += 3;
        if (n != 13)                begin errors++; $display("FAIL single_latency got=%0d exp=13 edges after accept", n); end
        if (out_sum !== 9'h100)     begin errors++; $display("FAIL single_sum got=%h exp=100", out_sum); end
        if (result_count !== 8'h01) begin errors++; $display("FAIL single_count got=%h exp=01", result_count); end
        wait_drain(100);
    endtask

    task automatic test_back_to_back();
        int tq[$];
        int n = 0;
        out_ready = 1'b1;
        push_pair(8'h12, 8'h34);
        push_pair(8'h80, 8'h80);
        push_pair(8'h00, 8'h00);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full in_ready got=%b exp=0", in_ready); end
        while (tq.size() < 3 && n < 80) begin
            @(negedge clock);
            if (out_valid) tq.push_back(cyc);
            n++;
        end
        checks++;
        if (tq.size() != 3) begin
            errors++; $display("FAIL b2b_results got=%0d exp=3", tq.size());
        end else begin
            checks++;
            if (tq[1] - tq[0] != 13 || tq[2] - tq[1] != 13) begin
                errors++; $display("FAIL b2b_spacing got=%0d,%0d exp=13,13", tq[1] - tq[0], tq[2] - tq[1]);
            end
        end
        wait_drain(100);
        checks += 2;
        if (in_ready !== 1'b1)      begin errors++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        if (result_count !== 8'h04) begin errors++; $display("FAIL b2b_count got=%h exp=04", result_count); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        @(posedge clock);
        #1 out_ready = 1'b0;
        push_pair(8'h10, 8'h20);
        push_pair(8'h7F, 8'h7F);
        while (!out_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        repeat (20) @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks += 3;
            if (add_start !== 1'b0)  begin errors++; $display("FAIL bp_add_start got=%b exp=0", add_start); end
            if (out_sum !== 9'h030)  begin errors++; $display("FAIL bp_hold_sum got=%h exp=030", out_sum); end
            if (out_valid !== 1'b1)  begin errors++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
        end
        checks++;
        if (result_count !== 8'h05) begin errors++; $display("FAIL bp_count_stall got=%h exp=05", result_count); end
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(posedge clock);
        #1;
        checks += 3;
        if (out_valid !== 1'b1)     begin errors++; $display("FAIL bp_same_cycle_valid got=%b exp=1", out_valid); end
        if (out_sum !== 9'h0FE)     begin errors++; $display("FAIL bp_same_cycle_sum got=%h exp=0fe", out_sum); end
        if (result_count !== 8'h06) begin errors++; $display("FAIL bp_count got=%h exp=06", result_count); end
        wait_drain(100);
    endtask

    task automatic test_random();
        bit done = 0;
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        fork
            begin
                for (int i = 0; i < 257; i++) begin
                    push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clock);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain(400);
        checks += 2;
        if (result_count !== 8'h01) begin errors++; $display("FAIL rand_count got=%h exp=01", result_count); end
        if (sb.size() != 0)         begin errors++; $display("FAIL rand_leftover got=%0d exp=0", sb.size()); end
    endtask

    initial begin
        // Scoreboard monitor: each consumed result must match the oldest expected sum
        fork
            forever begin
                @(negedge clock);
                if (!reset && out_valid && out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected got=%h exp=none", out_sum);
                    end else begin
                        mon_exp = sb.pop_front();
                        if (out_sum !== mon_exp) begin
                            errors++;
                            $display("FAIL sb_sum got=%h exp=%h", out_sum, mon_exp);
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_reset_midop();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
